// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI bridge.
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [3:0] ID_INST_DEFAULT = 4'd0;
    localparam logic [3:0] ID_DATA_DEFAULT = 4'd1;

    // Single-beat incrementing bursts, no locking, no cache hints, unprivileged.
    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    // CPU size (bytes = 2**size) maps straight onto AXI size.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges an SRAM-like inst/data CPU interface onto a single AXI master port.
// One read and one write may be in flight; a data read and a write never overlap.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter logic [3:0] ID_INST = ID_INST_DEFAULT,
    parameter logic [3:0] ID_DATA = ID_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_inst_req,
    input  logic [31:0] io_inst_addr,
    input  logic [1:0]  io_inst_size,
    output logic        io_inst_addr_ok,
    output logic        io_inst_data_ok,
    output logic [31:0] io_inst_rdata,

    input  logic        io_data_req,
    input  logic        io_data_wr,
    input  logic [1:0]  io_data_size,
    input  logic [31:0] io_data_addr,
    input  logic [31:0] io_data_wdata,
    input  logic [3:0]  io_data_wstrb,
    output logic        io_data_addr_ok,
    output logic        io_data_data_ok,
    output logic [31:0] io_data_rdata,

    output logic [3:0]  io_axi_ar_bits_id,
    output logic [31:0] io_axi_ar_bits_addr,
    output logic [7:0]  io_axi_ar_bits_len,
    output logic [2:0]  io_axi_ar_bits_size,
    output logic [1:0]  io_axi_ar_bits_burst,
    output logic [1:0]  io_axi_ar_bits_lock,
    output logic [3:0]  io_axi_ar_bits_cache,
    output logic [2:0]  io_axi_ar_bits_prot,
    output logic        io_axi_ar_valid,
    input  logic        io_axi_ar_ready,

    input  logic [3:0]  io_axi_r_bits_id,
    input  logic [31:0] io_axi_r_bits_data,
    input  logic [1:0]  io_axi_r_bits_resp,
    input  logic        io_axi_r_bits_last,
    input  logic        io_axi_r_valid,
    output logic        io_axi_r_ready,

    output logic [3:0]  io_axi_aw_bits_id,
    output logic [31:0] io_axi_aw_bits_addr,
    output logic [7:0]  io_axi_aw_bits_len,
    output logic [2:0]  io_axi_aw_bits_size,
    output logic [1:0]  io_axi_aw_bits_burst,
    output logic [1:0]  io_axi_aw_bits_lock,
    output logic [3:0]  io_axi_aw_bits_cache,
    output logic [2:0]  io_axi_aw_bits_prot,
    output logic        io_axi_aw_valid,
    input  logic        io_axi_aw_ready,

    output logic [3:0]  io_axi_w_bits_id,
    output logic [31:0] io_axi_w_bits_data,
    output logic [3:0]  io_axi_w_bits_strb,
    output logic        io_axi_w_bits_last,
    output logic        io_axi_w_valid,
    input  logic        io_axi_w_ready,

    input  logic [3:0]  io_axi_b_bits_id,
    input  logic [1:0]  io_axi_b_bits_resp,
    input  logic        io_axi_b_valid,
    output logic        io_axi_b_ready
);

    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [3:0]  ar_id_q, ar_id_d;
    logic [31:0] rdata_q, rdata_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;

    wr_state_e   wr_state_q, wr_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;

    logic rd_is_data;
    logic rd_data_busy;
    logic rd_can_grant;
    logic wr_can_grant;
    logic data_rd_req;
    logic r_done;
    logic r_done_data;
    logic b_ready_c;
    logic b_fire;
    logic unused_inputs;

    // Ownership, grant and completion decodes shared by both FSMs.
    assign rd_is_data   = (ar_id_q == ID_DATA);
    assign rd_data_busy = (rd_state_q != R_IDLE) && rd_is_data;
    assign rd_can_grant = (rd_state_q == R_IDLE) && (wr_state_q == W_IDLE);
    assign wr_can_grant = (wr_state_q == W_IDLE) && !rd_data_busy;
    assign data_rd_req  = io_data_req && !io_data_wr;
    assign r_done       = (rd_state_q == R_R) && io_axi_r_valid && io_axi_r_bits_last;
    assign r_done_data  = r_done && rd_is_data;
    // A data-read completion owns the data_ok pulse; the B response waits a cycle.
    assign b_ready_c    = (wr_state_q == W_B) && !r_done_data;
    assign b_fire       = b_ready_c && io_axi_b_valid;

    assign unused_inputs = ^{io_axi_r_bits_id, io_axi_r_bits_resp,
                             io_axi_b_bits_id, io_axi_b_bits_resp};

    // Read FSM next state: data read beats inst fetch, only when no write is in flight.
    always_comb begin
        rd_state_d = rd_state_q;
        ar_addr_d  = ar_addr_q;
        ar_size_d  = ar_size_q;
        ar_id_d    = ar_id_q;
        rdata_d    = rdata_q;
        inst_ok_d  = 1'b0;
        data_ok_d  = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (rd_can_grant && data_rd_req) begin
                    ar_addr_d  = io_data_addr;
                    ar_size_d  = axi_size(io_data_size);
                    ar_id_d    = ID_DATA;
                    rd_state_d = R_AR;
                end else if (rd_can_grant && io_inst_req) begin
                    ar_addr_d  = io_inst_addr;
                    ar_size_d  = axi_size(io_inst_size);
                    ar_id_d    = ID_INST;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                if (io_axi_ar_ready) rd_state_d = R_R;
            end
            R_R: begin
                if (r_done) begin
                    rdata_d    = io_axi_r_bits_data;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        inst_ok_d = r_done && !rd_is_data;
        data_ok_d = r_done_data || b_fire;
    end

    // Write FSM next state: AW and W complete independently, then wait for B.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        aw_size_d  = aw_size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (io_data_req && io_data_wr && wr_can_grant) begin
                    aw_addr_d  = io_data_addr;
                    aw_size_d  = axi_size(io_data_size);
                    wdata_d    = io_data_wdata;
                    wstrb_d    = io_data_wstrb;
                    aw_pend_d  = 1'b1;
                    w_pend_d   = 1'b1;
                    wr_state_d = W_SEND;
                end
            end
            W_SEND: begin
                aw_pend_d = aw_pend_q && !io_axi_aw_ready;
                w_pend_d  = w_pend_q && !io_axi_w_ready;
                if (!aw_pend_d && !w_pend_d) wr_state_d = W_B;
            end
            W_B: begin
                if (b_fire) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // State and payload registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            ar_addr_q  <= 32'd0;
            ar_size_q  <= 3'd0;
            ar_id_q    <= 4'd0;
            rdata_q    <= 32'd0;
            inst_ok_q  <= 1'b0;
            data_ok_q  <= 1'b0;
            wr_state_q <= W_IDLE;
            aw_addr_q  <= 32'd0;
            aw_size_q  <= 3'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_size_q  <= ar_size_d;
            ar_id_q    <= ar_id_d;
            rdata_q    <= rdata_d;
            inst_ok_q  <= inst_ok_d;
            data_ok_q  <= data_ok_d;
            wr_state_q <= wr_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_size_q  <= aw_size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_pend_q  <= aw_pend_d;
            w_pend_q   <= w_pend_d;
        end
    end

    // CPU side: addr_ok follows FSM state; inst loses to a pending data read.
    assign io_data_addr_ok = !reset && (io_data_wr ? wr_can_grant : rd_can_grant);
    assign io_inst_addr_ok = !reset && rd_can_grant && !data_rd_req;
    assign io_inst_data_ok = inst_ok_q;
    assign io_data_data_ok = data_ok_q;
    assign io_inst_rdata   = rdata_q;
    assign io_data_rdata   = rdata_q;

    // AXI read channels.
    assign io_axi_ar_bits_id    = ar_id_q;
    assign io_axi_ar_bits_addr  = ar_addr_q;
    assign io_axi_ar_bits_len   = AXI_LEN;
    assign io_axi_ar_bits_size  = ar_size_q;
    assign io_axi_ar_bits_burst = AXI_BURST;
    assign io_axi_ar_bits_lock  = AXI_LOCK;
    assign io_axi_ar_bits_cache = AXI_CACHE;
    assign io_axi_ar_bits_prot  = AXI_PROT;
    assign io_axi_ar_valid      = (rd_state_q == R_AR);
    assign io_axi_r_ready       = (rd_state_q == R_R);

    // AXI write channels.
    assign io_axi_aw_bits_id    = ID_DATA;
    assign io_axi_aw_bits_addr  = aw_addr_q;
    assign io_axi_aw_bits_len   = AXI_LEN;
    assign io_axi_aw_bits_size  = aw_size_q;
    assign io_axi_aw_bits_burst = AXI_BURST;
    assign io_axi_aw_bits_lock  = AXI_LOCK;
    assign io_axi_aw_bits_cache = AXI_CACHE;
    assign io_axi_aw_bits_prot  = AXI_PROT;
    assign io_axi_aw_valid      = aw_pend_q;
    assign io_axi_w_bits_id     = ID_DATA;
    assign io_axi_w_bits_data   = wdata_q;
    assign io_axi_w_bits_strb   = wstrb_q;
    assign io_axi_w_bits_last   = 1'b1;
    assign io_axi_w_valid       = w_pend_q;
    assign io_axi_b_ready       = b_ready_c;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: reset, inst/data reads, writes, hazards, mid-read reset.
module tb_cpu_axi_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0]  inst_size;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic [3:0]  ar_id, aw_id, w_id, r_id, b_id;
    logic [31:0] ar_addr, aw_addr, w_data, r_data;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size, ar_prot, aw_prot;
    logic [1:0]  ar_burst, aw_burst, ar_lock, aw_lock, r_resp, b_resp;
    logic [3:0]  ar_cache, aw_cache, w_strb;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cpu_axi_bridge dut (
        .clock(clock), .reset(reset),
        .io_inst_req(inst_req), .io_inst_addr(inst_addr), .io_inst_size(inst_size),
        .io_inst_addr_ok(inst_addr_ok), .io_inst_data_ok(inst_data_ok), .io_inst_rdata(inst_rdata),
        .io_data_req(data_req), .io_data_wr(data_wr), .io_data_size(data_size),
        .io_data_addr(data_addr), .io_data_wdata(data_wdata), .io_data_wstrb(data_wstrb),
        .io_data_addr_ok(data_addr_ok), .io_data_data_ok(data_data_ok), .io_data_rdata(data_rdata),
        .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_addr(ar_addr), .io_axi_ar_bits_len(ar_len),
        .io_axi_ar_bits_size(ar_size), .io_axi_ar_bits_burst(ar_burst), .io_axi_ar_bits_lock(ar_lock),
        .io_axi_ar_bits_cache(ar_cache), .io_axi_ar_bits_prot(ar_prot),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
        .io_axi_r_bits_id(r_id), .io_axi_r_bits_data(r_data), .io_axi_r_bits_resp(r_resp),
        .io_axi_r_bits_last(r_last), .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
        .io_axi_aw_bits_id(aw_id), .io_axi_aw_bits_addr(aw_addr), .io_axi_aw_bits_len(aw_len),
        .io_axi_aw_bits_size(aw_size), .io_axi_aw_bits_burst(aw_burst), .io_axi_aw_bits_lock(aw_lock),
        .io_axi_aw_bits_cache(aw_cache), .io_axi_aw_bits_prot(aw_prot),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
        .io_axi_w_bits_id(w_id), .io_axi_w_bits_data(w_data), .io_axi_w_bits_strb(w_strb),
        .io_axi_w_bits_last(w_last), .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_b_bits_id(b_id), .io_axi_b_bits_resp(b_resp),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_addr = 0; inst_size = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        ar_ready = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0; r_valid = 0;
        aw_ready = 0; w_ready = 0; b_id = 0; b_resp = 0; b_valid = 0;
        repeat (2) tick();

        // Reset state.
        check_val("rst_arvalid", 32'(ar_valid), 0);
        check_val("rst_rready", 32'(r_ready), 0);
        check_val("rst_awvalid", 32'(aw_valid), 0);
        check_val("rst_wvalid", 32'(w_valid), 0);
        check_val("rst_bready", 32'(b_ready), 0);
        check_val("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        check_val("rst_data_addr_ok", 32'(data_addr_ok), 0);
        check_val("rst_inst_data_ok", 32'(inst_data_ok), 0);
        check_val("rst_data_data_ok", 32'(data_data_ok), 0);
        check_val("rst_araddr", ar_addr, 0);
        reset = 1'b0;

        // Instruction fetch, R three cycles after the AR handshake.
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; #1;
        check_val("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        tick(); inst_req = 0;
        check_val("t1_arvalid", 32'(ar_valid), 1);
        check_val("t1_araddr", ar_addr, 32'hBFC0_0000);
        check_val("t1_arid", 32'(ar_id), 0);
        check_val("t1_arsize", 32'(ar_size), 2);
        check_val("t1_arlen", 32'(ar_len), 0);
        check_val("t1_arburst", 32'(ar_burst), 1);
        ar_ready = 1;
        tick(); ar_ready = 0;
        check_val("t1_arvalid_drop", 32'(ar_valid), 0);
        check_val("t1_rready", 32'(r_ready), 1);
        tick();
        check_val("t1_no_early_ok", 32'(inst_data_ok), 0);
        tick();
        r_valid = 1; r_last = 1; r_data = 32'h3C1D_BFC0;
        tick(); r_valid = 0;
        check_val("t1_inst_data_ok", 32'(inst_data_ok), 1);
        check_val("t1_inst_rdata", inst_rdata, 32'h3C1D_BFC0);
        check_val("t1_data_ok_quiet", 32'(data_data_ok), 0);
        check_val("t1_rready_drop", 32'(r_ready), 0);
        tick();
        check_val("t1_ok_one_cycle", 32'(inst_data_ok), 0);

        // Data read beats inst fetch; inst waits for R to complete.
        data_req = 1; data_wr = 0; data_addr = 32'h8000_2000; data_size = 2;
        inst_req = 1; inst_addr = 32'hBFC0_0004; #1;
        check_val("t2_data_addr_ok", 32'(data_addr_ok), 1);
        check_val("t2_inst_blocked", 32'(inst_addr_ok), 0);
        tick(); data_req = 0; #1;
        check_val("t2_arid_data", 32'(ar_id), 1);
        check_val("t2_araddr", ar_addr, 32'h8000_2000);
        check_val("t2_inst_wait_ar", 32'(inst_addr_ok), 0);
        ar_ready = 1;
        tick(); ar_ready = 0;
        check_val("t2_inst_wait_r", 32'(inst_addr_ok), 0);
        r_valid = 1; r_data = 32'h1234_5678;
        tick(); r_valid = 0; #1;
        check_val("t2_data_data_ok", 32'(data_data_ok), 1);
        check_val("t2_data_rdata", data_rdata, 32'h1234_5678);
        check_val("t2_inst_ok_quiet", 32'(inst_data_ok), 0);
        check_val("t2_inst_addr_ok", 32'(inst_addr_ok), 1);
        tick(); inst_req = 0;
        check_val("t2_arid_inst", 32'(ar_id), 0);
        check_val("t2_araddr_inst", ar_addr, 32'hBFC0_0004);
        ar_ready = 1;
        tick(); ar_ready = 0;
        r_valid = 1; r_data = 32'h0000_AAAA;
        tick(); r_valid = 0;
        check_val("t2_inst_data_ok", 32'(inst_data_ok), 1);
        check_val("t2_inst_rdata", inst_rdata, 32'h0000_AAAA);
        check_val("t2_data_ok_quiet", 32'(data_data_ok), 0);

        // Write: AW handshakes two cycles before W.
        tick();
        data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'hF; data_size = 2; #1;
        check_val("t3_addr_ok", 32'(data_addr_ok), 1);
        tick(); data_req = 0;
        check_val("t3_awvalid", 32'(aw_valid), 1);
        check_val("t3_wvalid", 32'(w_valid), 1);
        check_val("t3_awaddr", aw_addr, 32'h8000_1000);
        check_val("t3_awid", 32'(aw_id), 1);
        check_val("t3_wid", 32'(w_id), 1);
        check_val("t3_awsize", 32'(aw_size), 2);
        check_val("t3_wdata", w_data, 32'hDEAD_BEEF);
        check_val("t3_wstrb", 32'(w_strb), 32'hF);
        check_val("t3_wlast", 32'(w_last), 1);
        aw_ready = 1;
        tick(); aw_ready = 0;
        check_val("t3_awvalid_drop", 32'(aw_valid), 0);
        check_val("t3_wvalid_held", 32'(w_valid), 1);
        tick();
        check_val("t3_wvalid_held2", 32'(w_valid), 1);
        check_val("t3_no_bready", 32'(b_ready), 0);
        w_ready = 1;
        tick(); w_ready = 0;
        check_val("t3_wvalid_drop", 32'(w_valid), 0);
        check_val("t3_bready", 32'(b_ready), 1);
        check_val("t3_no_early_ok", 32'(data_data_ok), 0);

        // Data read while write waits on B: blocked until the B handshake.
        data_req = 1; data_wr = 0; data_addr = 32'h8000_3000; #1;
        check_val("t4_addr_ok_blocked", 32'(data_addr_ok), 0);
        tick();
        check_val("t4_addr_ok_blocked2", 32'(data_addr_ok), 0);
        check_val("t4_no_ok", 32'(data_data_ok), 0);
        check_val("t4_no_arvalid", 32'(ar_valid), 0);
        b_valid = 1;
        tick(); b_valid = 0; #1;
        check_val("t4_write_ok", 32'(data_data_ok), 1);
        check_val("t4_bready_drop", 32'(b_ready), 0);
        check_val("t4_addr_ok_open", 32'(data_addr_ok), 1);
        tick(); data_req = 0;
        check_val("t4_arvalid", 32'(ar_valid), 1);
        check_val("t4_araddr", ar_addr, 32'h8000_3000);
        check_val("t4_ok_one_cycle", 32'(data_data_ok), 0);
        ar_ready = 1;
        tick(); ar_ready = 0;
        r_valid = 1; r_data = 32'hCAFE_F00D;
        tick(); r_valid = 0;
        check_val("t4_read_ok", 32'(data_data_ok), 1);
        check_val("t4_rdata", data_rdata, 32'hCAFE_F00D);

        // Inst read and data write granted in the same cycle.
        tick();
        inst_req = 1; inst_addr = 32'hBFC0_0100; inst_size = 2;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_5000; data_wdata = 32'h0BAD_F00D;
        data_wstrb = 4'h3; data_size = 1; #1;
        check_val("t5_inst_addr_ok", 32'(inst_addr_ok), 1);
        check_val("t5_data_addr_ok", 32'(data_addr_ok), 1);
        tick(); inst_req = 0; data_req = 0;
        check_val("t5_arvalid", 32'(ar_valid), 1);
        check_val("t5_awvalid", 32'(aw_valid), 1);
        check_val("t5_awsize", 32'(aw_size), 1);
        ar_ready = 1; aw_ready = 1; w_ready = 1;
        tick(); ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 1; r_data = 32'h7777_0001; b_valid = 1;
        tick(); r_valid = 0; b_valid = 0;
        check_val("t5_inst_data_ok", 32'(inst_data_ok), 1);
        check_val("t5_data_data_ok", 32'(data_data_ok), 1);
        check_val("t5_inst_rdata", inst_rdata, 32'h7777_0001);

        // Reset during R_R abandons the read.
        tick();
        data_req = 1; data_wr = 0; data_addr = 32'h8000_4000; data_size = 2;
        tick(); data_req = 0;
        ar_ready = 1;
        tick(); ar_ready = 0;
        check_val("t6_rready", 32'(r_ready), 1);
        reset = 1; #1;
        check_val("t6_rst_arvalid", 32'(ar_valid), 0);
        check_val("t6_rst_rready", 32'(r_ready), 0);
        tick(); reset = 0;
        r_valid = 1; r_last = 1; r_data = 32'h5555_5555;
        tick();
        check_val("t6_no_data_ok", 32'(data_data_ok), 0);
        check_val("t6_no_inst_ok", 32'(inst_data_ok), 0);
        check_val("t6_rready_low", 32'(r_ready), 0);
        r_valid = 0;
        tick();
        check_val("t6_no_data_ok2", 32'(data_data_ok), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
